// File: rtl/commit_trace_checker_if.sv
// Golden-record load port and retirement port of the commit trace checker.
// The master side is the loader/core; the slave side is the checker.
interface commit_trace_checker_if;
    logic        exp_valid;
    logic        exp_ready;
    logic [1:0]  exp_kind;
    logic [1:0]  exp_mem;
    logic [15:0] exp_pc;
    logic [2:0]  exp_reg;
    logic [15:0] exp_wdata;
    logic [15:0] exp_addr;
    logic [15:0] exp_mdata;

    logic        cm_valid;
    logic [15:0] cm_pc;
    logic        cm_regwrite;
    logic [2:0]  cm_reg;
    logic [15:0] cm_wdata;
    logic        cm_memread;
    logic        cm_memwrite;
    logic [15:0] cm_addr;
    logic [15:0] cm_mdata;
    logic        cm_halt;

    modport master (
        output exp_valid, exp_kind, exp_mem, exp_pc, exp_reg, exp_wdata, exp_addr, exp_mdata,
        output cm_valid, cm_pc, cm_regwrite, cm_reg, cm_wdata, cm_memread, cm_memwrite,
        output cm_addr, cm_mdata, cm_halt,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_kind, exp_mem, exp_pc, exp_reg, exp_wdata, exp_addr, exp_mdata,
        input  cm_valid, cm_pc, cm_regwrite, cm_reg, cm_wdata, cm_memread, cm_memwrite,
        input  cm_addr, cm_mdata, cm_halt,
        output exp_ready
    );
endinterface

// File: rtl/commit_trace_checker.sv
// Compares every retired instruction against a buffered golden trace record and
// reports done/fail, the first failing instruction number and a retire count.
module commit_trace_checker #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                   clk,
    input  logic                   rst,   // asynchronous, active LOW despite the name
    commit_trace_checker_if.slave  bus,
    output logic                   done,
    output logic                   fail,
    output logic [1:0]             err_code,
    output logic [15:0]            fail_inum,
    output logic [15:0]            inst_count
);

    localparam logic [1:0] KIND_NOP  = 2'd0;
    localparam logic [1:0] KIND_REG  = 2'd1;
    localparam logic [1:0] KIND_ST   = 2'd2;
    localparam logic [1:0] KIND_HALT = 2'd3;

    localparam logic [1:0] ERR_FIELD    = 2'd1;
    localparam logic [1:0] ERR_UNDER    = 2'd2;
    localparam logic [1:0] ERR_LEFTOVER = 2'd3;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  mem;
        logic [15:0] pc;
        logic [2:0]  rd;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] mdata;
    } rec_t;

    typedef enum logic [1:0] {RUN, DONE, FAIL} state_t;

    state_t        state;
    rec_t          fifoMem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;

    logic full, empty, push, pop, commitRun, mismatch, leftover;
    rec_t pushRec, head;
    logic [1:0] cmKind;

    assign full          = (count == FULL_COUNT);
    assign empty         = (count == '0);
    assign bus.exp_ready = (state == RUN) & ~full;
    assign push          = bus.exp_valid & bus.exp_ready;
    assign commitRun     = bus.cm_valid & (state == RUN);
    assign pop           = commitRun & ~empty;
    assign head          = fifoMem[rdPtr];
    // After popping the halt record nothing may remain, nor may a record arrive now.
    assign leftover      = (count != (AW + 1)'(1)) | push;

    assign pushRec = '{kind:  bus.exp_kind,  mem:   bus.exp_mem,  pc:    bus.exp_pc,
                       rd:    bus.exp_reg,   wdata: bus.exp_wdata,
                       addr:  bus.exp_addr,  mdata: bus.exp_mdata};

    always_comb begin
        cmKind = KIND_NOP;
        if (bus.cm_regwrite)      cmKind = KIND_REG;
        else if (bus.cm_halt)     cmKind = KIND_HALT;
        else if (bus.cm_memwrite) cmKind = KIND_ST;
    end

    always_comb begin
        mismatch = (head.kind != cmKind) | (head.pc != bus.cm_pc);
        case (head.kind)
            KIND_REG: begin
                mismatch = mismatch | (head.rd != bus.cm_reg) | (head.wdata != bus.cm_wdata)
                         | (head.mem != {bus.cm_memread, bus.cm_memwrite});
                if (head.mem[1]) mismatch = mismatch | (head.addr != bus.cm_addr);
                if (head.mem[0]) mismatch = mismatch | (head.addr != bus.cm_addr)
                                                     | (head.mdata != bus.cm_mdata);
            end
            KIND_ST: mismatch = mismatch | (head.addr != bus.cm_addr)
                                         | (head.mdata != bus.cm_mdata);
            default: ;
        endcase
    end

    // Storage is not reset; emptying the pointers/count is what clears the FIFO.
    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= pushRec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            err_code   <= 2'd0;
            fail_inum  <= 16'd0;
            inst_count <= 16'd0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);

            if (commitRun) begin
                inst_count <= inst_count + 16'd1;
                if (empty) begin
                    state     <= FAIL;
                    fail      <= 1'b1;
                    err_code  <= ERR_UNDER;
                    fail_inum <= inst_count;
                end else if (mismatch) begin
                    state     <= FAIL;
                    fail      <= 1'b1;
                    err_code  <= ERR_FIELD;
                    fail_inum <= inst_count;
                end else if (head.kind == KIND_HALT) begin
                    if (leftover) begin
                        state     <= FAIL;
                        fail      <= 1'b1;
                        err_code  <= ERR_LEFTOVER;
                        fail_inum <= inst_count;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed, table-driven bench for commit_trace_checker plus hand-written
// sequences for FIFO-full push/pop and asynchronous reset mid-run.
module tb_commit_trace_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    commit_trace_checker_if bus();
    logic        done, fail;
    logic [1:0]  err_code;
    logic [15:0] fail_inum, inst_count;

    commit_trace_checker #(.DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .done       (done),
        .fail       (fail),
        .err_code   (err_code),
        .fail_inum  (fail_inum),
        .inst_count (inst_count)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  mem;
        logic [15:0] pc;
        logic [2:0]  rd;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] mdata;
    } rec_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        regwrite;
        logic [2:0]  rd;
        logic [15:0] wdata;
        logic        memread;
        logic        memwrite;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic        halt;
    } cm_t;

    typedef struct {
        bit          doReset;
        bit          push;
        rec_t        rec;
        bit          commit;
        cm_t         cm;
        logic        eDone;
        logic        eFail;
        logic [1:0]  eErr;
        logic [15:0] eInum;
        logic [15:0] eCount;
        logic        eReady;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    function automatic rec_t rReg(logic [15:0] pc, logic [2:0] rd, logic [15:0] wd,
                                  logic [1:0] mem, logic [15:0] addr, logic [15:0] md);
        return '{kind: 2'd1, mem: mem, pc: pc, rd: rd, wdata: wd, addr: addr, mdata: md};
    endfunction
    function automatic rec_t rSt(logic [15:0] pc, logic [15:0] addr, logic [15:0] md);
        return '{kind: 2'd2, mem: 2'd0, pc: pc, rd: 3'd0, wdata: 16'd0, addr: addr, mdata: md};
    endfunction
    function automatic rec_t rNop(logic [15:0] pc);
        return '{kind: 2'd0, mem: 2'd0, pc: pc, rd: 3'd0, wdata: 16'd0, addr: 16'd0, mdata: 16'd0};
    endfunction
    function automatic rec_t rHalt(logic [15:0] pc);
        return '{kind: 2'd3, mem: 2'd0, pc: pc, rd: 3'd0, wdata: 16'd0, addr: 16'd0, mdata: 16'd0};
    endfunction

    function automatic cm_t cReg(logic [15:0] pc, logic [2:0] rd, logic [15:0] wd, logic mr,
                                 logic mw, logic [15:0] addr, logic [15:0] md);
        return '{pc: pc, regwrite: 1'b1, rd: rd, wdata: wd, memread: mr, memwrite: mw,
                 addr: addr, mdata: md, halt: 1'b0};
    endfunction
    function automatic cm_t cSt(logic [15:0] pc, logic [15:0] addr, logic [15:0] md);
        return '{pc: pc, regwrite: 1'b0, rd: 3'd0, wdata: 16'd0, memread: 1'b0, memwrite: 1'b1,
                 addr: addr, mdata: md, halt: 1'b0};
    endfunction
    function automatic cm_t cNop(logic [15:0] pc);
        return '{pc: pc, regwrite: 1'b0, rd: 3'd0, wdata: 16'd0, memread: 1'b0, memwrite: 1'b0,
                 addr: 16'd0, mdata: 16'd0, halt: 1'b0};
    endfunction
    function automatic cm_t cHalt(logic [15:0] pc);
        return '{pc: pc, regwrite: 1'b0, rd: 3'd0, wdata: 16'd0, memread: 1'b0, memwrite: 1'b0,
                 addr: 16'd0, mdata: 16'd0, halt: 1'b1};
    endfunction

    function automatic vec_t V(bit r, bit p, rec_t rec, bit c, cm_t cm, logic d, logic f,
                               logic [1:0] e, logic [15:0] inum, logic [15:0] cnt, logic rdy);
        return '{doReset: r, push: p, rec: rec, commit: c, cm: cm, eDone: d, eFail: f,
                 eErr: e, eInum: inum, eCount: cnt, eReady: rdy};
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(bit p, rec_t r, bit c, cm_t m);
        bus.exp_valid   = p;
        bus.exp_kind    = r.kind;
        bus.exp_mem     = r.mem;
        bus.exp_pc      = r.pc;
        bus.exp_reg     = r.rd;
        bus.exp_wdata   = r.wdata;
        bus.exp_addr    = r.addr;
        bus.exp_mdata   = r.mdata;
        bus.cm_valid    = c;
        bus.cm_pc       = m.pc;
        bus.cm_regwrite = m.regwrite;
        bus.cm_reg      = m.rd;
        bus.cm_wdata    = m.wdata;
        bus.cm_memread  = m.memread;
        bus.cm_memwrite = m.memwrite;
        bus.cm_addr     = m.addr;
        bus.cm_mdata    = m.mdata;
        bus.cm_halt     = m.halt;
    endtask

    task automatic doReset();
        @(negedge clk);
        drive(0, '0, 0, '0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(bit p, rec_t r, bit c, cm_t m);
        @(negedge clk);
        drive(p, r, c, m);
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(string tag, logic d, logic f, logic [1:0] e, logic [15:0] inum,
                            logic [15:0] cnt, logic rdy);
        chk({tag, ".done"},       16'(done),          16'(d));
        chk({tag, ".fail"},       16'(fail),          16'(f));
        chk({tag, ".err_code"},   16'(err_code),      16'(e));
        chk({tag, ".fail_inum"},  fail_inum,          inum);
        chk({tag, ".inst_count"}, inst_count,         cnt);
        chk({tag, ".exp_ready"},  16'(bus.exp_ready), 16'(rdy));
    endtask

    vec_t tbl[$];
    cm_t  regHalt;

    initial begin
        drive(0, '0, 0, '0);
        regHalt = cReg(16'd6, 3'd5, 16'd1, 1'b0, 1'b0, 16'd0, 16'd0);
        regHalt.halt = 1'b1;

        // REG then HALT: clean run to done
        tbl.push_back(V(1, 1, rReg(16'h0000, 3'd1, 16'h0005, 2'b00, 0, 0), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rHalt(16'h0002), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cReg(16'h0000, 3'd1, 16'h0005, 0, 0, 0, 0), 0, 0, 0, 0, 1, 1));
        tbl.push_back(V(0, 0, '0, 1, cHalt(16'h0002), 1, 0, 0, 0, 2, 0));
        tbl.push_back(V(0, 0, '0, 1, cNop(16'h0004), 1, 0, 0, 0, 2, 0));
        // wdata mismatch; later commits and pushes ignored
        tbl.push_back(V(1, 1, rReg(16'h0000, 3'd3, 16'h1234, 2'b00, 0, 0), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cReg(16'h0000, 3'd3, 16'h1235, 0, 0, 0, 0), 0, 1, 1, 0, 1, 0));
        tbl.push_back(V(0, 1, rNop(16'h2), 1, cReg(16'h0000, 3'd3, 16'h1234, 0, 0, 0, 0), 0, 1, 1, 0, 1, 0));
        // underflow
        tbl.push_back(V(1, 0, '0, 1, cNop(16'h0000), 0, 1, 2, 0, 1, 0));
        // ST ok, then HALT against a NOP record
        tbl.push_back(V(1, 1, rSt(16'h0004, 16'h0010, 16'hBEEF), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rNop(16'h0006), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rHalt(16'h0008), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cSt(16'h0004, 16'h0010, 16'hBEEF), 0, 0, 0, 0, 1, 1));
        tbl.push_back(V(0, 0, '0, 1, cHalt(16'h0006), 0, 1, 1, 1, 2, 0));
        // halt with a record still queued
        tbl.push_back(V(1, 1, rHalt(16'h0000), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rNop(16'h0002), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cHalt(16'h0000), 0, 1, 3, 0, 1, 0));
        // halt while a record is being pushed in the same cycle
        tbl.push_back(V(1, 1, rHalt(16'h0000), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rNop(16'h0002), 1, cHalt(16'h0000), 0, 1, 3, 0, 1, 0));
        // load, store-update, NOP, regwrite beating halt, clean halt
        tbl.push_back(V(1, 1, rReg(16'h0000, 3'd2, 16'h0007, 2'b10, 16'h0020, 0), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rReg(16'h0002, 3'd4, 16'h0009, 2'b01, 16'h0030, 16'h0055), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rNop(16'h0004), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rReg(16'h0006, 3'd5, 16'h0001, 2'b00, 0, 0), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rHalt(16'h0008), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cReg(16'h0000, 3'd2, 16'h0007, 1, 0, 16'h0020, 16'h0999), 0, 0, 0, 0, 1, 1));
        tbl.push_back(V(0, 0, '0, 1, cReg(16'h0002, 3'd4, 16'h0009, 0, 1, 16'h0030, 16'h0055), 0, 0, 0, 0, 2, 1));
        tbl.push_back(V(0, 0, '0, 1, cNop(16'h0004), 0, 0, 0, 0, 3, 1));
        tbl.push_back(V(0, 0, '0, 1, regHalt, 0, 0, 0, 0, 4, 1));
        tbl.push_back(V(0, 0, '0, 1, cHalt(16'h0008), 1, 0, 0, 0, 5, 0));
        // single-field mismatches
        tbl.push_back(V(1, 1, rReg(16'h0000, 3'd2, 16'h0007, 2'b10, 16'h0020, 0), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cReg(16'h0000, 3'd2, 16'h0007, 1, 0, 16'h0021, 0), 0, 1, 1, 0, 1, 0));
        tbl.push_back(V(1, 1, rSt(16'h0004, 16'h0010, 16'hBEEF), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cSt(16'h0004, 16'h0010, 16'hBEEE), 0, 1, 1, 0, 1, 0));
        tbl.push_back(V(1, 1, rReg(16'h0000, 3'd1, 16'h0005, 2'b00, 0, 0), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cReg(16'h0000, 3'd1, 16'h0005, 1, 0, 0, 0), 0, 1, 1, 0, 1, 0));
        tbl.push_back(V(1, 1, rReg(16'h0002, 3'd4, 16'h0009, 2'b01, 16'h0030, 16'h0055), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cReg(16'h0002, 3'd4, 16'h0009, 0, 1, 16'h0030, 16'h0056), 0, 1, 1, 0, 1, 0));
        tbl.push_back(V(1, 1, rReg(16'h0000, 3'd1, 16'h0005, 2'b00, 0, 0), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cReg(16'h0000, 3'd2, 16'h0005, 0, 0, 0, 0), 0, 1, 1, 0, 1, 0));
        tbl.push_back(V(1, 1, rNop(16'h0004), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, rNop(16'h0006), 0, '0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, '0, 1, cNop(16'h0004), 0, 0, 0, 0, 1, 1));
        tbl.push_back(V(0, 0, '0, 1, cNop(16'h0008), 0, 1, 1, 1, 2, 0));

        foreach (tbl[i]) begin
            if (tbl[i].doReset) begin
                doReset();
                if (i == 0) checkAll("reset", 0, 0, 0, 0, 0, 1);
            end
            step(tbl[i].push, tbl[i].rec, tbl[i].commit, tbl[i].cm);
            checkAll($sformatf("row%0d", i), tbl[i].eDone, tbl[i].eFail, tbl[i].eErr,
                     tbl[i].eInum, tbl[i].eCount, tbl[i].eReady);
        end

        // FIFO full: the push offered alongside a pop is refused
        doReset();
        for (int i = 0; i < 8; i++)
            step(1, rReg(16'(2 * i), i[2:0], 16'(i), 2'b00, 0, 0), 0, '0);
        chk("full.exp_ready", 16'(bus.exp_ready), 16'd0);
        step(1, rReg(16'h0010, 3'd0, 16'hAAAA, 2'b00, 0, 0), 1, cReg(16'h0000, 3'd0, 16'h0000, 0, 0, 0, 0));
        checkAll("fullpop", 0, 0, 0, 0, 1, 1);
        step(0, '0, 0, '0);
        chk("fullnext.exp_ready", 16'(bus.exp_ready), 16'd1);
        for (int i = 1; i < 8; i++)
            step(0, '0, 1, cReg(16'(2 * i), i[2:0], 16'(i), 0, 0, 0, 0));
        checkAll("drain", 0, 0, 0, 0, 8, 1);
        step(0, '0, 1, cReg(16'h0010, 3'd0, 16'hAAAA, 0, 0, 0, 0));
        checkAll("refused", 0, 1, 2, 8, 9, 0);

        // asynchronous reset mid-run with records queued
        doReset();
        for (int i = 0; i < 5; i++)
            step(1, rReg(16'(2 * i), 3'd1, 16'(i + 1), 2'b00, 0, 0), 0, '0);
        step(0, '0, 1, cReg(16'h0000, 3'd1, 16'h0001, 0, 0, 0, 0));
        step(0, '0, 1, cReg(16'h0002, 3'd1, 16'h0063, 0, 0, 0, 0));
        checkAll("prereset", 0, 1, 1, 1, 2, 0);
        @(negedge clk);
        drive(0, '0, 0, '0);
        #2 rst = 1'b0;
        #1 checkAll("asyncrst", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        step(0, '0, 1, cNop(16'h0000));
        checkAll("postrst", 0, 1, 2, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
